// File: rtl/sat_pkg.sv
// Shared types and helpers for the SAT solver datapath.
//   lit_t           : one clause literal {valid, polarity, var_id}
//   clause_status_e : outcome of evaluating a clause against the variable state
//   imply_entry_t   : one pending implication {var_id, val}
//   classify_clause : combinational clause classifier used by bcp_core
package sat_pkg;

    localparam int MAX_VARS_BITS    = 8;
    localparam int MAX_CLAUSES_BITS = 10;
    localparam int NUM_LITS         = 3;

    typedef struct packed {
        logic                     valid;
        logic                     polarity;
        logic [MAX_VARS_BITS-1:0] var_id;
    } lit_t;

    typedef enum logic [1:0] {
        CL_SAT,
        CL_UNIT,
        CL_CONFLICT,
        CL_UNRES
    } clause_status_e;

    typedef struct packed {
        logic [MAX_VARS_BITS-1:0] var_id;
        logic                     val;
    } imply_entry_t;

    typedef struct packed {
        clause_status_e status;
        imply_entry_t   imp;
    } clause_result_t;

    // A literal is TRUE when assigned with val==polarity, FALSE when assigned
    // otherwise, OPEN when unassigned. Invalid slots do not participate, so a
    // clause with no valid slot has no TRUE and no OPEN literal: a conflict.
    function automatic clause_result_t classify_clause(
        input lit_t [NUM_LITS-1:0] lits,
        input logic [NUM_LITS-1:0] val,
        input logic [NUM_LITS-1:0] unassign
    );
        clause_result_t res;
        logic           any_true;
        int unsigned    n_open;
        any_true   = 1'b0;
        n_open     = 0;
        res.status = CL_UNRES;
        res.imp    = '0;
        for (int i = 0; i < NUM_LITS; i++) begin
            if (lits[i].valid) begin
                if (unassign[i]) begin
                    n_open         = n_open + 1;
                    res.imp.var_id = lits[i].var_id;
                    res.imp.val    = lits[i].polarity;
                end else if (val[i] == lits[i].polarity) begin
                    any_true = 1'b1;
                end
            end
        end
        if (any_true) begin
            res.status = CL_SAT;
        end else if (n_open == 0) begin
            res.status = CL_CONFLICT;
        end else if (n_open == 1) begin
            res.status = CL_UNIT;
        end else begin
            res.status = CL_UNRES;
        end
        return res;
    endfunction

endpackage

// File: rtl/bcp_pend_fifo.sv
// Pending-implication FIFO between the BCP classifier and the imply queue.
// Ports:
//   clock, reset    : clock, synchronous active-low reset
//   clear           : synchronous flush (empties the FIFO)
//   wr_en, wr_data  : write one imply_entry_t
//   rd_en           : pop the head entry (ignored when empty)
//   rd_data         : head entry (combinational)
//   full, empty     : occupancy flags
//   overflow        : one-cycle pulse when a write is dropped (full, no pop)
module bcp_pend_fifo
    import sat_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         wr_en,
    input  imply_entry_t wr_data,
    input  logic         rd_en,
    output imply_entry_t rd_data,
    output logic         full,
    output logic         empty,
    output logic         overflow
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    imply_entry_t mem [DEPTH];
    logic         do_wr;
    logic         do_rd;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd    = rd_en & ~empty;
    // A pop in the same cycle frees the slot, so a write while full is legal then.
    assign do_wr    = wr_en & (~full | do_rd);
    assign overflow = wr_en & full & ~do_rd;
    assign rd_data  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (do_rd) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clock) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/bcp_core.sv
// Boolean-constraint-propagation engine. For each clause index it reads the
// clause literals, looks up their variable values, classifies the clause and
// either queues a unit implication or raises a sticky conflict.
// Ports:
//   clock, reset            : clock, synchronous active-low reset
//   clear                   : flush pipeline, pending FIFO and conflict flag
//   en, clause_idx          : clause index stream from control (no backpressure)
//   cdb_rd_en, cdb_addr     : clause-DB read (combinational from en/clause_idx)
//   cdb_lits                : clause literals, one cycle after the read
//   vs_rd_en, vs_var        : variable-state read for all literal slots
//   vs_val, vs_unassign     : per-slot value/unassigned, one cycle after the read
//   push_imply, var_imply,
//   val_imply, type_imply   : implication output toward the imply queue
//   full_imply              : imply queue full
//   busy                    : work in flight
//   conflict                : sticky conflict flag (cleared by clear/reset)
//   overflow                : sticky pending-FIFO overflow (cleared by reset only)
module bcp_core #(
    parameter int MAX_VARS_BITS    = sat_pkg::MAX_VARS_BITS,
    parameter int MAX_CLAUSES_BITS = sat_pkg::MAX_CLAUSES_BITS,
    parameter int LITS             = sat_pkg::NUM_LITS,
    parameter int PEND_DEPTH       = 4
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              clear,
    input  logic                              en,
    input  logic [MAX_CLAUSES_BITS-1:0]       clause_idx,
    output logic                              cdb_rd_en,
    output logic [MAX_CLAUSES_BITS-1:0]       cdb_addr,
    input  logic [LITS*(MAX_VARS_BITS+2)-1:0] cdb_lits,
    output logic                              vs_rd_en,
    output logic [LITS*MAX_VARS_BITS-1:0]     vs_var,
    input  logic [LITS-1:0]                   vs_val,
    input  logic [LITS-1:0]                   vs_unassign,
    output logic                              push_imply,
    output logic [MAX_VARS_BITS-1:0]          var_imply,
    output logic                              val_imply,
    output logic                              type_imply,
    input  logic                              full_imply,
    output logic                              busy,
    output logic                              conflict,
    output logic                              overflow
);

    import sat_pkg::*;

    logic            vld_p1;
    logic            vld_p2;
    lit_t [LITS-1:0] lits_p1;
    lit_t [LITS-1:0] lits_p2;
    clause_result_t  res_p2;
    logic            fifo_wr;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_ovf;
    imply_entry_t    fifo_head;

    // ---- S0: clause-DB read issued straight from the index stream ----
    assign cdb_rd_en = en;
    assign cdb_addr  = clause_idx;

    always_ff @(posedge clock) begin
        if (!reset) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= en & ~clear;
        end
    end

    // ---- S1: literals arrive, variable-state read issued ----
    assign lits_p1  = cdb_lits;
    assign vs_rd_en = vld_p1;

    always_comb begin
        vs_var = '0;
        if (vld_p1) begin
            for (int i = 0; i < LITS; i++) begin
                vs_var[i*MAX_VARS_BITS +: MAX_VARS_BITS] = lits_p1[i].var_id;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            vld_p2 <= 1'b0;
        end else begin
            vld_p2 <= vld_p1 & ~clear;
        end
    end

    always_ff @(posedge clock) begin
        lits_p2 <= lits_p1;
    end

    // ---- S2: values arrive, clause classified, result committed at the edge ----
    always_comb begin
        res_p2 = classify_clause(lits_p2, vs_val, vs_unassign);
    end

    // Once a conflict is seen, further implications are pointless.
    assign fifo_wr = vld_p2 & ~clear & ~conflict & (res_p2.status == CL_UNIT);

    always_ff @(posedge clock) begin
        if (!reset) begin
            conflict <= 1'b0;
        end else if (clear) begin
            conflict <= 1'b0;
        end else if (vld_p2 && (res_p2.status == CL_CONFLICT)) begin
            conflict <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (fifo_ovf) begin
            overflow <= 1'b1;
        end
    end

    bcp_pend_fifo #(
        .DEPTH(PEND_DEPTH)
    ) u_pend_fifo (
        .clock    (clock),
        .reset    (reset),
        .clear    (clear),
        .wr_en    (fifo_wr),
        .wr_data  (res_p2.imp),
        .rd_en    (push_imply),
        .rd_data  (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .overflow (fifo_ovf)
    );

    // ---- S3: implication output from the FIFO head ----
    assign push_imply = ~fifo_empty & ~full_imply & ~conflict;
    assign var_imply  = push_imply ? fifo_head.var_id : '0;
    assign val_imply  = push_imply & fifo_head.val;
    assign type_imply = 1'b1;

    // Entries stranded behind a conflict will never drain, so they are not work.
    assign busy = en | vld_p1 | vld_p2 | (~fifo_empty & ~conflict);

    logic unused_full;
    assign unused_full = fifo_full;

endmodule
